fifo2pcie_arb: RTL and testbench

FIFO2PCIE_ARB -- requirements
Module: fifo2pcie_arb

---
 rtl/fifo2pcie_arb_pkg.sv | 31 +++
 rtl/fifo2pcie_arb_rr.sv | 32 +++
 rtl/fifo2pcie_arb.sv | 143 ++++++++++++++
 tb/tb_fifo2pcie_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo2pcie_arb_pkg.sv
// Shared types for the FIFO-to-PCIe TX arbiter: FIFO word layout, FSM states
// and the index-width helper used to size channel selectors.
package fifo2pcie_arb_pkg;

  // FIFO words are laid out for the widest legal TLP width (128 bits);
  // narrower instances use the low C_DATA_WIDTH bits only.
  localparam int TX_DATA_W = 128;
  localparam int TX_KEEP_W = TX_DATA_W / 8;
  localparam int TUSER_W   = 4;

  typedef struct packed {
    logic                 data_valid;
    logic                 tvalid;
    logic                 tlast;
    logic [TX_KEEP_W-1:0] tkeep;
    logic [TX_DATA_W-1:0] tdata;
    logic [TUSER_W-1:0]   tuser;
  } PCIE_FIFO_TX_T;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_REQ  = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo2pcie_arb_rr.sv
// Combinational round-robin selector: grants the first requester found after
// the last served index, wrapping around.
module rr_arbiter
  import fifo2pcie_arb_pkg::*;
#(
  parameter int N   = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);
  logic [IW-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value held, which is what would otherwise infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Scan farthest-first so the nearest requester after 'last' wins.
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo2pcie_arb.sv
// Arbitrates complete packets from NCH first-word-fall-through FIFOs onto one
// shared PCIe AXI-Stream TX port, round-robin between eligible channels.
module fifo2pcie_arb
  import fifo2pcie_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int NCH          = 2,
  parameter int CNT_W        = 8,
  localparam int CH_W        = idx_w(NCH)
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,
  output logic [NCH-1:0]          ch_rd_en,
  input  PCIE_FIFO_TX_T [NCH-1:0] ch_dout,
  input  logic [NCH-1:0]          ch_empty,
  input  logic [NCH-1:0]          ch_pkt_done,
  output logic                    pcie_tx_req,
  input  logic                    pcie_tx_ack,
  input  logic                    pcie_tready,
  output logic                    pcie_tvalid,
  output logic                    pcie_tlast,
  output logic [KEEP_WIDTH-1:0]   pcie_tkeep,
  output logic [C_DATA_WIDTH-1:0] pcie_tdata,
  output logic [TUSER_W-1:0]      pcie_tuser,
  output logic [CH_W-1:0]         cur_ch,
  output logic [NCH-1:0]          ovf
);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_e           state_q, state_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] pend_q [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [NCH-1:0]   eligible, dec;
  logic             gnt_valid;
  logic [CH_W-1:0]  gnt_idx;
  PCIE_FIFO_TX_T    sel_word;
  logic             sel_empty, beat_acc, beat_last;
  logic             unused_word;

  assign sel_word    = ch_dout[cur_ch_q];
  assign sel_empty   = ch_empty[cur_ch_q];
  assign unused_word = ^{sel_word.tdata, sel_word.tkeep};
  assign cur_ch      = cur_ch_q;
  assign ovf         = ovf_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eligible[i] = (pend_q[i] != '0) && !ch_empty[i];
      dec[i]      = beat_last && (cur_ch_q == CH_W'(i));
    end
  end

  rr_arbiter #(.N(NCH)) u_rr (
    .req      (eligible),
    .last     (last_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    last_d      = last_q;
    ch_rd_en    = '0;
    pcie_tx_req = 1'b0;
    pcie_tvalid = 1'b0;
    pcie_tlast  = 1'b0;
    pcie_tkeep  = '0;
    pcie_tdata  = '0;
    pcie_tuser  = '0;
    beat_acc    = 1'b0;
    beat_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          cur_ch_d = gnt_idx;
          state_d  = ST_ARB;
        end
      end
      ST_ARB: begin
        // Bubble words (data_valid == 0) ahead of a packet are discarded here.
        if (sel_empty)                state_d = ST_IDLE;
        else if (sel_word.data_valid) state_d = ST_REQ;
        else                          ch_rd_en[cur_ch_q] = 1'b1;
      end
      ST_REQ: begin
        pcie_tx_req = 1'b1;
        if (pcie_tx_ack) state_d = ST_SEND;
      end
      ST_SEND: begin
        pcie_tx_req        = 1'b1;
        pcie_tvalid        = sel_word.tvalid && !sel_empty;
        pcie_tlast         = sel_word.tlast;
        pcie_tkeep         = sel_word.tkeep[KEEP_WIDTH-1:0];
        pcie_tdata         = sel_word.tdata[C_DATA_WIDTH-1:0];
        pcie_tuser         = sel_word.tuser;
        beat_acc           = pcie_tvalid && pcie_tready;
        beat_last          = beat_acc && sel_word.tlast;
        ch_rd_en[cur_ch_q] = beat_acc;
        if (beat_last) begin
          state_d = ST_IDLE;
          last_d  = cur_ch_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and updates together, independent of block ordering.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q  <= ST_IDLE;
      cur_ch_q <= '0;
      last_q   <= CH_W'(NCH - 1);
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
    end
  end

  // A packet arriving and one leaving in the same cycle cancel out.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      for (int i = 0; i < NCH; i++) pend_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_pkt_done[i] && !dec[i]) begin
          if (pend_q[i] == PEND_MAX) ovf_q[i] <= 1'b1;
          else                       pend_q[i] <= pend_q[i] + CNT_W'(1);
        end else if (dec[i] && !ch_pkt_done[i] && pend_q[i] != '0) begin
          pend_q[i] <= pend_q[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo2pcie_arb.sv
// Scoreboard bench for fifo2pcie_arb: FWFT FIFO model per channel, expected
// beats queued at push time and popped as the PCIe port accepts them.
`timescale 1ns/1ps
module tb_fifo2pcie_arb;
  import fifo2pcie_arb_pkg::*;

  localparam int DW = 64, KW = 8, NCH = 2, CNT_W = 8, CH_W = 1;

  logic                    pcie_clk = 1'b0;
  logic                    pcie_rst_n;
  logic [NCH-1:0]          ch_rd_en, ch_empty, ch_pkt_done, ovf;
  PCIE_FIFO_TX_T [NCH-1:0] ch_dout;
  logic                    pcie_tx_req, pcie_tx_ack, pcie_tready;
  logic                    pcie_tvalid, pcie_tlast;
  logic [KW-1:0]           pcie_tkeep;
  logic [DW-1:0]           pcie_tdata;
  logic [3:0]              pcie_tuser;
  logic [CH_W-1:0]         cur_ch;

  always #5 pcie_clk = ~pcie_clk;

  fifo2pcie_arb #(.C_DATA_WIDTH(DW), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
    .ch_rd_en(ch_rd_en), .ch_dout(ch_dout), .ch_empty(ch_empty),
    .ch_pkt_done(ch_pkt_done), .pcie_tx_req(pcie_tx_req),
    .pcie_tx_ack(pcie_tx_ack), .pcie_tready(pcie_tready),
    .pcie_tvalid(pcie_tvalid), .pcie_tlast(pcie_tlast),
    .pcie_tkeep(pcie_tkeep), .pcie_tdata(pcie_tdata),
    .pcie_tuser(pcie_tuser), .cur_ch(cur_ch), .ovf(ovf)
  );

  typedef struct {
    logic [CH_W-1:0] ch;
    logic            last;
    logic [KW-1:0]   keep;
    logic [DW-1:0]   data;
    logic [3:0]      user;
  } beat_t;

  beat_t         exp_q[$];
  PCIE_FIFO_TX_T fifo_q [NCH][$];
  int            n_cmp = 0, n_err = 0;
  int            rd_cnt [NCH];
  int            arb_rd [NCH];
  int            req_rises, pkt_id;
  logic          obs_req, obs_tvalid, hold_valid;
  logic [77:0]   hold_vec;

  task automatic update_fifo_outputs();
    for (int c = 0; c < NCH; c++) begin
      ch_empty[c] = (fifo_q[c].size() == 0);
      ch_dout[c]  = ch_empty[c] ? '0 : fifo_q[c][0];
    end
  endtask

  task automatic clear_tb();
    for (int c = 0; c < NCH; c++) begin
      fifo_q[c].delete();
      rd_cnt[c] = 0;
      arb_rd[c] = 0;
    end
    exp_q.delete();
    req_rises   = 0;
    obs_req     = 1'b0;
    obs_tvalid  = 1'b0;
    hold_valid  = 1'b0;
    ch_pkt_done = '0;
    pcie_tx_ack = 1'b0;
    pcie_tready = 1'b1;
    update_fifo_outputs();
  endtask

  task automatic apply_reset();
    pcie_rst_n = 1'b0;
    clear_tb();
    repeat (2) @(posedge pcie_clk);
    #1 pcie_rst_n = 1'b1;
  endtask

  // One clock: observe at negedge, advance FIFO model just after posedge.
  task automatic cycle();
    logic [NCH-1:0] pop;
    beat_t e;
    @(negedge pcie_clk);
    n_cmp++;
    if ($countones(ch_rd_en) > 1) begin
      n_err++;
      $display("FAIL rd_en_onehot: got %b required at most one bit", ch_rd_en);
    end
    for (int c = 0; c < NCH; c++) if (ch_rd_en[c]) begin
      rd_cnt[c]++;
      if (!pcie_tx_req) arb_rd[c]++;
      n_cmp++;
      if (fifo_q[c].size() == 0) begin
        n_err++;
        $display("FAIL rd_en_on_empty: ch%0d read while empty", c);
      end
    end
    if (pcie_tx_req && !obs_req) req_rises++;
    obs_req    = pcie_tx_req;
    obs_tvalid = pcie_tvalid;
    if (hold_valid) begin
      n_cmp++;
      if ({pcie_tvalid, pcie_tlast, pcie_tdata, pcie_tkeep, pcie_tuser} !== hold_vec) begin
        n_err++;
        $display("FAIL stall_hold: got %h required %h",
                 {pcie_tvalid, pcie_tlast, pcie_tdata, pcie_tkeep, pcie_tuser}, hold_vec);
      end
    end
    hold_valid = pcie_tvalid && !pcie_tready;
    hold_vec   = {pcie_tvalid, pcie_tlast, pcie_tdata, pcie_tkeep, pcie_tuser};
    if (pcie_tvalid && pcie_tready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_beat: got data %h with nothing expected", pcie_tdata);
      end else begin
        e = exp_q.pop_front();
        if ({cur_ch, pcie_tlast, pcie_tkeep, pcie_tdata, pcie_tuser} !==
            {e.ch, e.last, e.keep, e.data, e.user}) begin
          n_err++;
          $display("FAIL beat: got ch%0d last=%b keep=%h data=%h user=%h required ch%0d last=%b keep=%h data=%h user=%h",
                   cur_ch, pcie_tlast, pcie_tkeep, pcie_tdata, pcie_tuser,
                   e.ch, e.last, e.keep, e.data, e.user);
        end
      end
    end
    pop = ch_rd_en;
    @(posedge pcie_clk);
    #1;
    for (int c = 0; c < NCH; c++) if (pop[c] && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
    ch_pkt_done = '0;
    pcie_tx_ack = obs_req;
    update_fifo_outputs();
  endtask

  task automatic push_packet(input int ch, input int nbeats, input int nbub);
    PCIE_FIFO_TX_T w;
    beat_t e;
    for (int b = 0; b < nbub; b++) begin
      w = '0;
      w.tdata[31:0] = $urandom;
      fifo_q[ch].push_back(w);
    end
    for (int b = 0; b < nbeats; b++) begin
      w = '0;
      w.data_valid     = 1'b1;
      w.tvalid         = 1'b1;
      w.tlast          = (b == nbeats - 1);
      w.tkeep          = w.tlast ? 16'h000F : 16'h00FF;
      w.tdata[DW-1:0]  = {8'(ch), 8'(b), 16'(pkt_id), 32'($urandom)};
      w.tuser          = 4'($urandom);
      fifo_q[ch].push_back(w);
      e.ch   = CH_W'(ch);
      e.last = w.tlast;
      e.keep = w.tkeep[KW-1:0];
      e.data = w.tdata[DW-1:0];
      e.user = w.tuser;
      exp_q.push_back(e);
    end
    pkt_id++;
    update_fifo_outputs();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (exp_q.size() == 0 && !obs_req) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    clear_tb();
    pcie_rst_n  = 1'b0;
    pcie_tx_ack = 1'b1;
    push_packet(0, 2, 0);
    ch_pkt_done = 2'b01;
    @(negedge pcie_clk);
    n_cmp++;
    if ({ch_rd_en, pcie_tx_req, pcie_tvalid, pcie_tlast, pcie_tkeep, pcie_tdata, pcie_tuser, cur_ch, ovf} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rd_en=%b req=%b tvalid=%b tdata=%h cur_ch=%0d ovf=%b required all 0",
               ch_rd_en, pcie_tx_req, pcie_tvalid, pcie_tdata, cur_ch, ovf);
    end
    @(posedge pcie_clk);
    #1;
    pcie_rst_n  = 1'b1;
    ch_pkt_done = '0;
    pcie_tx_ack = 1'b0;
    repeat (6) cycle();
    n_cmp++;
    if (req_rises != 0 || rd_cnt[0] != 0) begin
      n_err++;
      $display("FAIL reset_pkt_done_ignored: req_rises=%0d rd_cnt=%0d required 0/0", req_rises, rd_cnt[0]);
    end
    n_cmp++;
    if (dut.pend_q[0] !== 8'd0 || dut.last_q !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: pend0=%0d last=%0d required 0/1", dut.pend_q[0], dut.last_q);
    end
  endtask

  task automatic test_single_packet();
    apply_reset();
    push_packet(0, 3, 0);
    ch_pkt_done = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      n_cmp++;
      if (obs_req !== (c == 4)) begin
        n_err++;
        $display("FAIL req_latency: cycle %0d got req=%b required %b", c, obs_req, c == 4);
      end
    end
    run_until_idle("single", 40);
    n_cmp++;
    if (rd_cnt[0] != 3 || rd_cnt[1] != 0 || dut.pend_q[0] !== 8'd0) begin
      n_err++;
      $display("FAIL single_counts: rd0=%0d rd1=%0d pend0=%0d required 3/0/0", rd_cnt[0], rd_cnt[1], dut.pend_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_packet(0, 2, 0);
    push_packet(1, 3, 0);
    push_packet(0, 1, 0);
    push_packet(1, 2, 0);
    ch_pkt_done = 2'b11;
    cycle();
    ch_pkt_done = 2'b11;
    run_until_idle("rr", 200);
    n_cmp++;
    if (req_rises != 4 || rd_cnt[0] != 3 || rd_cnt[1] != 5) begin
      n_err++;
      $display("FAIL rr_counts: req_rises=%0d rd0=%0d rd1=%0d required 4/3/5", req_rises, rd_cnt[0], rd_cnt[1]);
    end
  endtask

  task automatic test_bubbles();
    apply_reset();
    push_packet(1, 3, 2);
    ch_pkt_done = 2'b10;
    run_until_idle("bubble", 60);
    n_cmp++;
    if (arb_rd[1] != 2 || rd_cnt[1] != 5 || rd_cnt[0] != 0) begin
      n_err++;
      $display("FAIL bubble_counts: arb_rd1=%0d rd1=%0d rd0=%0d required 2/5/0", arb_rd[1], rd_cnt[1], rd_cnt[0]);
    end
  endtask

  task automatic test_tready_stall();
    bit seen = 0;
    apply_reset();
    push_packet(0, 4, 0);
    ch_pkt_done = 2'b01;
    pcie_tready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = obs_tvalid;
    end
    pcie_tready = 1'b1; cycle();
    pcie_tready = 1'b0; cycle();
    pcie_tready = 1'b0; cycle();
    pcie_tready = 1'b1;
    run_until_idle("stall", 40);
    n_cmp++;
    if (!seen || rd_cnt[0] != 4) begin
      n_err++;
      $display("FAIL stall_counts: tvalid_seen=%b rd0=%0d required 1/4", seen, rd_cnt[0]);
    end
  endtask

  task automatic test_overflow();
    bit seen = 0;
    apply_reset();
    for (int i = 0; i < 255; i++) begin
      ch_pkt_done = 2'b01;
      cycle();
    end
    n_cmp++;
    if (dut.pend_q[0] !== 8'd255 || ovf !== 2'b00) begin
      n_err++;
      $display("FAIL pend_at_max: pend0=%0d ovf=%b required 255/00", dut.pend_q[0], ovf);
    end
    ch_pkt_done = 2'b01;
    cycle();
    n_cmp++;
    if (dut.pend_q[0] !== 8'd255 || ovf !== 2'b01) begin
      n_err++;
      $display("FAIL overflow: pend0=%0d ovf=%b required 255/01", dut.pend_q[0], ovf);
    end
    push_packet(0, 1, 0);
    pcie_tready = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = obs_tvalid;
    end
    pcie_tready = 1'b1;
    ch_pkt_done = 2'b01;
    cycle();
    n_cmp++;
    if (!seen || dut.pend_q[0] !== 8'd255 || ovf !== 2'b01) begin
      n_err++;
      $display("FAIL inc_dec_same_cycle: seen=%b pend0=%0d ovf=%b required 1/255/01", seen, dut.pend_q[0], ovf);
    end
    run_until_idle("ovf", 20);
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    push_packet(1, 4, 0);
    ch_pkt_done = 2'b10;
    for (int i = 0; i < 30 && exp_q.size() > 2; i++) cycle();
    @(negedge pcie_clk);
    #2 pcie_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ch_rd_en, pcie_tx_req, pcie_tvalid, pcie_tlast, pcie_tkeep, pcie_tdata, pcie_tuser, cur_ch} !== '0
        || dut.state_q !== ST_IDLE) begin
      n_err++;
      $display("FAIL async_abort: rd_en=%b req=%b tvalid=%b tdata=%h cur_ch=%0d required all 0 and IDLE",
               ch_rd_en, pcie_tx_req, pcie_tvalid, pcie_tdata, cur_ch);
    end
    @(negedge pcie_clk);
    #2 pcie_rst_n = 1'b1;
    @(posedge pcie_clk);
    #1;
    hold_valid  = 1'b0;
    obs_req     = 1'b0;
    pcie_tx_ack = 1'b0;
    req_rises   = 0;
    rd_cnt[1]   = 0;
    repeat (10) cycle();
    n_cmp++;
    if (rd_cnt[1] != 0 || req_rises != 0 || fifo_q[1].size() != 2) begin
      n_err++;
      $display("FAIL post_reset_quiet: rd1=%0d req_rises=%0d fifo1=%0d required 0/0/2", rd_cnt[1], req_rises, fifo_q[1].size());
    end
    ch_pkt_done = 2'b10;
    run_until_idle("resume", 40);
    n_cmp++;
    if (rd_cnt[1] != 2) begin
      n_err++;
      $display("FAIL resume_count: rd1=%0d required 2", rd_cnt[1]);
    end
  endtask

  initial begin
    pcie_rst_n = 1'b1;
    pkt_id     = 0;
    #2;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_bubbles();
    test_tready_stall();
    test_reset_mid_packet();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
